// File: rtl/time_adjust.sv
// ============================================================================
// Module   : time_adjust
// Brief    : Key-driven hour/minute/second editor with a one-cycle commit strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module time_adjust #(
  parameter int REPEAT_CYCLES = 5,
  parameter int HOUR_MAX      = 23,
  parameter int MS_MAX        = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] add_select,
  input  logic       adj_en,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic [1:0] field_sel,
  output logic       adjusting,
  output logic       set_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADJ  = 2'd1;
  localparam logic [1:0] S_REP  = 2'd2;

  localparam int             c_CNT_W    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_REP_LAST = c_CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [4:0]     c_HOUR_MAX = 5'(HOUR_MAX);
  localparam logic [5:0]     c_MS_MAX   = 6'(MS_MAX);

  logic [1:0]         r_state;
  logic               r_en_prev;
  logic [2:0]         r_sel_prev;
  logic [c_CNT_W-1:0] r_rep_cnt;

  logic       w_en_rise, w_en_fall, w_inc_evt, w_fld_evt, w_long_lvl;
  logic       w_rep_due, w_do_inc;
  logic [4:0] w_hour_inc;
  logic [5:0] w_min_inc, w_sec_inc;

  assign w_en_rise  =  adj_en & ~r_en_prev;
  assign w_en_fall  = ~adj_en &  r_en_prev;
  assign w_inc_evt  = (add_select == 3'b001) && (r_sel_prev != 3'b001);
  assign w_fld_evt  = (add_select == 3'b010) && (r_sel_prev != 3'b010);
  assign w_long_lvl = (add_select == 3'b100);
  assign w_rep_due  = (r_rep_cnt == c_REP_LAST);

  // Single increment point shared by press, first long-press step and auto-repeat.
  assign w_do_inc = ((r_state == S_ADJ) && !w_en_fall &&
                     (w_inc_evt || (!w_fld_evt && w_long_lvl))) ||
                    ((r_state == S_REP) && !w_en_fall && w_long_lvl && w_rep_due);

  // Out-of-range values loaded from the live counter wrap on their first increment.
  assign w_hour_inc = (set_hour >= c_HOUR_MAX) ? 5'd0 : set_hour + 5'd1;
  assign w_min_inc  = (set_min  >= c_MS_MAX)   ? 6'd0 : set_min  + 6'd1;
  assign w_sec_inc  = (set_sec  >= c_MS_MAX)   ? 6'd0 : set_sec  + 6'd1;

  assign adjusting = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_prev  <= 1'b0;
      r_sel_prev <= 3'b000;
    end else begin
      r_en_prev  <= adj_en;
      r_sel_prev <= add_select;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rep_cnt <= '0;
      field_sel <= 2'd0;
      set_valid <= 1'b0;
    end else begin
      set_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_en_rise) begin
            field_sel <= 2'd0;
            r_state   <= S_ADJ;
          end
        end
        S_ADJ: begin
          if (w_en_fall) begin
            set_valid <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_inc_evt) begin
            r_state <= S_ADJ;
          end else if (w_fld_evt) begin
            field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
          end else if (w_long_lvl) begin
            r_rep_cnt <= '0;
            r_state   <= S_REP;
          end
        end
        S_REP: begin
          if (w_en_fall) begin
            set_valid <= 1'b1;
            r_state   <= S_IDLE;
          end else if (!w_long_lvl) begin
            r_state <= S_ADJ;
          end else if (w_rep_due) begin
            r_rep_cnt <= '0;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_hour <= 5'd0;
      set_min  <= 6'd0;
      set_sec  <= 6'd0;
    end else if ((r_state == S_IDLE) && w_en_rise) begin
      set_hour <= cur_hour;
      set_min  <= cur_min;
      set_sec  <= cur_sec;
    end else if (w_do_inc) begin
      case (field_sel)
        2'd0:    set_hour <= w_hour_inc;
        2'd1:    set_min  <= w_min_inc;
        default: set_sec  <= w_sec_inc;
      endcase
    end
  end

endmodule

`default_nettype wire
